// File: rtl/data_ram_pkg.sv
// Shared definitions for the pipelined data RAM: size/error encodings and the
// load lane-extract/extend helper used by the s1 stage.
package data_ram_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE  = 2'd0,
      SZ_HALF  = 2'd1,
      SZ_WORD  = 2'd2,
      SZ_DWORD = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      ERR_OK       = 2'd0,
      ERR_MISALIGN = 2'd1,
      ERR_RANGE    = 2'd2,
      ERR_PARITY   = 2'd3
   } err_e;

   // Widest supported word; callers widen into and truncate from this size.
   localparam int MAX_W = 64;

   function automatic int lane_bits(input int data_w);
      return $clog2(data_w / 8);
   endfunction

   function automatic logic [MAX_W-1:0] lane_extend(input logic [MAX_W-1:0] word,
                                                    input logic [2:0]       lane,
                                                    input logic [1:0]       size,
                                                    input logic             sgn);
      logic [MAX_W-1:0] sh;
      logic [MAX_W-1:0] res;
      sh  = word >> {lane, 3'b000};
      res = sh;
      case (size)
         SZ_BYTE: res = {{56{sgn & sh[7]}},  sh[7:0]};
         SZ_HALF: res = {{48{sgn & sh[15]}}, sh[15:0]};
         SZ_WORD: res = {{32{sgn & sh[31]}}, sh[31:0]};
         default: res = sh;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/data_ram_pipe_if.sv
// Request/response channel between the MEM stage (master) and the data RAM (slave).
interface data_ram_pipe_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [1:0]        req_size;
   logic              req_signed;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic [1:0]        rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_size, req_signed, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/data_ram_rsp_fifo.sv
// Synchronous response FIFO with modulo-DEPTH pointers, occupancy count and sync reset.
module data_ram_rsp_fifo #(
   parameter int WIDTH = 34,
   parameter int DEPTH = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  logic [WIDTH-1:0]             din_i,
   input  logic                         pop_i,
   output logic [WIDTH-1:0]             dout_o,
   output logic                         valid_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_ptr_q];
   assign valid_o = (count_q != '0);
   assign count_o = count_q;

endmodule

// File: rtl/data_ram_pipe.sv
// Pipelined data memory: lane-steered stores, registered extended loads, in-order
// response FIFO. Define DATA_RAM_PARITY_EN to add per-byte even parity (err 3).
module data_ram_pipe
   import data_ram_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int MEM_WORDS = 1024,
   parameter int RSP_DEPTH = 3
) (
   input  logic            clk,
   input  logic            rst,
   data_ram_pipe_if.slave  bus
);
   localparam int BYTES  = DATA_W / 8;
   localparam int LANE_W = lane_bits(DATA_W);
   localparam int IDX_W  = $clog2(MEM_WORDS);
   localparam int CNT_W  = $clog2(RSP_DEPTH + 1);
   localparam int FIFO_W = DATA_W + 2;

   logic [DATA_W-1:0] mem_q [MEM_WORDS];

   logic [ADDR_W-1:0] word_idx;
   logic [LANE_W-1:0] lane;
   logic [IDX_W-1:0]  idx;
   logic [LANE_W-1:0] align_mask;
   logic [BYTES-1:0]  be;
   logic [DATA_W-1:0] wdata_sh;
   logic              size_bad, range_bad;
   err_e              req_err;
   logic              accept, wr_en;

   logic              s1_valid_q, s1_valid_d;
   logic [DATA_W-1:0] s1_word_q;
   logic [LANE_W-1:0] s1_lane_q;
   logic [1:0]        s1_size_q;
   logic              s1_signed_q;
   logic              s1_we_q;
   err_e              s1_err_q;
   err_e              s1_rsp_err;
   logic [DATA_W-1:0] s1_rsp_data;
   logic              par_bad;

   logic [FIFO_W-1:0] fifo_dout;
   logic              fifo_valid;
   logic [CNT_W-1:0]  fifo_count;

   // Accept stage: address decode, error classification, store lane steering
   assign word_idx = bus.req_addr >> LANE_W;
   assign lane     = bus.req_addr[LANE_W-1:0];
   assign idx      = word_idx[IDX_W-1:0];

   always_comb begin
      size_bad   = (32'(bus.req_size) > 32'(LANE_W));
      range_bad  = (word_idx >= ADDR_W'(MEM_WORDS));
      align_mask = LANE_W'((32'd1 << bus.req_size) - 32'd1);
      req_err    = ERR_OK;
      if (size_bad || range_bad)       req_err = ERR_RANGE;
      else if ((lane & align_mask) != '0) req_err = ERR_MISALIGN;
      be       = BYTES'((32'd1 << (32'd1 << bus.req_size)) - 32'd1) << lane;
      wdata_sh = bus.req_wdata << {lane, 3'b000};
   end

   assign bus.req_ready = !rst && ((32'(fifo_count) + 32'(s1_valid_q)) < 32'(RSP_DEPTH));
   assign accept        = bus.req_valid && bus.req_ready;
   assign wr_en         = accept && bus.req_we && (req_err == ERR_OK);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < BYTES; b++) begin
            if (be[b]) mem_q[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
         end
      end
   end

`ifdef DATA_RAM_PARITY_EN
   logic [BYTES-1:0] par_q [MEM_WORDS];
   logic [BYTES-1:0] s1_par_q;
   logic [BYTES-1:0] s1_be_q;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < BYTES; b++) begin
            if (be[b]) par_q[idx][b] <= ^wdata_sh[b*8 +: 8];
         end
      end
      if (accept) begin
         s1_par_q <= par_q[idx];
         s1_be_q  <= be;
      end
   end

   always_comb begin
      par_bad = 1'b0;
      for (int b = 0; b < BYTES; b++) begin
         if (s1_be_q[b] && ((^s1_word_q[b*8 +: 8]) != s1_par_q[b])) par_bad = 1'b1;
      end
   end
`else
   assign par_bad = 1'b0;
`endif

   // s1 stage: registered read word plus the request attributes needed to shape it
   assign s1_valid_d = accept;

   always_ff @(posedge clk) begin
      if (rst) s1_valid_q <= 1'b0;
      else     s1_valid_q <= s1_valid_d;
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         s1_word_q   <= mem_q[idx];
         s1_lane_q   <= lane;
         s1_size_q   <= bus.req_size;
         s1_signed_q <= bus.req_signed;
         s1_we_q     <= bus.req_we;
         s1_err_q    <= req_err;
      end
   end

   always_comb begin
      s1_rsp_err = ERR_OK;
      if (s1_err_q != ERR_OK)        s1_rsp_err = s1_err_q;
      else if (par_bad && !s1_we_q)  s1_rsp_err = ERR_PARITY;
      s1_rsp_data = '0;
      if ((s1_rsp_err == ERR_OK) && !s1_we_q) begin
         s1_rsp_data = DATA_W'(lane_extend(MAX_W'(s1_word_q), 3'(s1_lane_q),
                                           s1_size_q, s1_signed_q));
      end
   end

   // Response stage: FIFO head drives the response channel
   data_ram_rsp_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (s1_valid_q),
      .din_i   ({s1_rsp_err, s1_rsp_data}),
      .pop_i   (bus.rsp_valid && bus.rsp_ready),
      .dout_o  (fifo_dout),
      .valid_o (fifo_valid),
      .count_o (fifo_count)
   );

   assign bus.rsp_valid = fifo_valid;
   assign bus.rsp_rdata = fifo_valid ? fifo_dout[DATA_W-1:0] : '0;
   assign bus.rsp_err   = fifo_valid ? fifo_dout[DATA_W +: 2] : 2'b00;

endmodule

// File: tb/tb_data_ram_pipe.sv
// Directed bench for data_ram_pipe: lane steering, extension, errors, backpressure,
// read-after-write latency and mid-run reset; parity cases when DATA_RAM_PARITY_EN is set.
module tb_data_ram_pipe;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;

   data_ram_pipe_if #(.DATA_W(32), .ADDR_W(32)) bus ();

   data_ram_pipe #(
      .DATA_W    (32),
      .ADDR_W    (32),
      .MEM_WORDS (1024),
      .RSP_DEPTH (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] wdata);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_addr   = addr;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_wdata  = wdata;
   endtask

   task automatic send(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic sgn, input logic [31:0] wdata);
      int t = 0;
      drive(we, addr, size, sgn, wdata);
      @(negedge clk);
      while (!bus.req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("req_accept", 64'(bus.req_ready), 64'd1);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic recv(input string tag, input logic [31:0] exp_d, input logic [1:0] exp_e);
      int t = 0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      while (!bus.rsp_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_vld"},  64'(bus.rsp_valid), 64'd1);
      check({tag, "_data"}, 64'(bus.rsp_rdata), 64'(exp_d));
      check({tag, "_err"},  64'(bus.rsp_err),   64'(exp_e));
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
   endtask

   task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic sgn, input logic [31:0] wdata,
                       input logic [31:0] exp_d, input logic [1:0] exp_e);
      send(we, addr, size, sgn, wdata);
      recv(tag, exp_d, exp_e);
   endtask

   logic [31:0] bp_addr [5] = '{32'h10, 32'h20, 32'h04, 32'h10, 32'h20};
   logic [31:0] bp_exp  [5] = '{32'h8765_5A21, 32'hBEEF_1111, 32'hAABB_CCDD,
                                32'h8765_5A21, 32'hBEEF_1111};
   logic [31:0] got_d [4];
   int          got_n;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      rst            = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_addr   = '0;
      bus.req_size   = 2'd0;
      bus.req_signed = 1'b0;
      bus.req_wdata  = '0;
      bus.rsp_ready  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_req_ready", 64'(bus.req_ready), 64'd0);
      check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
      check("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Byte loads with sign and zero extension
      xact("st_w10",  1'b1, 32'h10, 2'd2, 1'b0, 32'h8765_4321, 32'h0,         2'd0);
      xact("ldb_s13", 1'b0, 32'h13, 2'd0, 1'b1, 32'h0,         32'hFFFF_FF87, 2'd0);
      xact("ldb_u12", 1'b0, 32'h12, 2'd0, 1'b0, 32'h0,         32'h0000_0065, 2'd0);
      xact("st_b11",  1'b1, 32'h11, 2'd0, 1'b0, 32'hFFFF_FF5A, 32'h0,         2'd0);
      xact("ldw_10",  1'b0, 32'h10, 2'd2, 1'b0, 32'h0,         32'h8765_5A21, 2'd0);

      // Halfword store into upper lane
      xact("st_w20",  1'b1, 32'h20, 2'd2, 1'b0, 32'h1111_1111, 32'h0,         2'd0);
      xact("st_h22",  1'b1, 32'h22, 2'd1, 1'b0, 32'h0000_BEEF, 32'h0,         2'd0);
      xact("ldw_20",  1'b0, 32'h20, 2'd2, 1'b0, 32'h0,         32'hBEEF_1111, 2'd0);
      xact("ldh_s22", 1'b0, 32'h22, 2'd1, 1'b1, 32'h0,         32'hFFFF_BEEF, 2'd0);
      xact("ldh_u20", 1'b0, 32'h20, 2'd1, 1'b0, 32'h0,         32'h0000_1111, 2'd0);

      // Misalignment and range errors
      xact("st_w04",  1'b1, 32'h04, 2'd2, 1'b0, 32'hAABB_CCDD, 32'h0,         2'd0);
      xact("ldw_06",  1'b0, 32'h06, 2'd2, 1'b0, 32'h0,         32'h0,         2'd1);
      xact("sth_05",  1'b1, 32'h05, 2'd1, 1'b0, 32'h0000_1234, 32'h0,         2'd1);
      xact("ldw_04",  1'b0, 32'h04, 2'd2, 1'b0, 32'h0,         32'hAABB_CCDD, 2'd0);
      xact("ld_oor",  1'b0, 32'd4096, 2'd2, 1'b0, 32'h0,       32'h0,         2'd2);
      xact("st_oor",  1'b1, 32'd4096, 2'd0, 1'b0, 32'h55,      32'h0,         2'd2);
      xact("ld_sz3",  1'b0, 32'h0, 2'd3, 1'b0, 32'h0,          32'h0,         2'd2);

      // Backpressure: only RSP_DEPTH requests get in while rsp_ready is low
      bus.rsp_ready = 1'b0;
      acc = 0;
      for (int c = 0; c < 6; c++) begin
         if (acc < 5) drive(1'b0, bp_addr[acc], 2'd2, 1'b0, 32'h0);
         @(negedge clk);
         if (bus.req_ready) acc++;
         @(posedge clk);
         #1;
      end
      bus.req_valid = 1'b0;
      check("bp_accepted", 64'(acc), 64'd3);
      @(negedge clk);
      check("bp_ready_low", 64'(bus.req_ready), 64'd0);
      check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) recv("bp_drain", bp_exp[i], 2'd0);

      // Full-rate streaming with rsp_ready held high
      got_n = 0;
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               drive(1'b0, bp_addr[i], 2'd2, 1'b0, 32'h0);
               @(negedge clk);
               check("stream_rdy", 64'(bus.req_ready), 64'd1);
               @(posedge clk);
               #1;
            end
            bus.req_valid = 1'b0;
         end
         begin
            bus.rsp_ready = 1'b1;
            for (int c = 0; c < 30 && got_n < 4; c++) begin
               @(negedge clk);
               if (bus.rsp_valid) begin
                  got_d[got_n] = bus.rsp_rdata;
                  got_n++;
               end
            end
         end
      join
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      check("stream_count", 64'(got_n), 64'd4);
      for (int i = 0; i < 4; i++) check("stream_data", 64'(got_d[i]), 64'(bp_exp[i]));

      // Read-after-write on consecutive cycles, exact latency
      xact("raw_init", 1'b1, 32'h30, 2'd2, 1'b0, 32'h0, 32'h0, 2'd0);
      bus.rsp_ready = 1'b1;
      drive(1'b1, 32'h30, 2'd2, 1'b0, 32'hCAFE_F00D);
      @(negedge clk);
      check("raw_st_rdy", 64'(bus.req_ready), 64'd1);
      @(posedge clk);
      #1 drive(1'b0, 32'h30, 2'd2, 1'b0, 32'h0);
      @(negedge clk);
      check("raw_ld_rdy", 64'(bus.req_ready), 64'd1);
      check("raw_n1_vld", 64'(bus.rsp_valid), 64'd0);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      @(negedge clk);
      check("raw_n2_vld",  64'(bus.rsp_valid), 64'd1);
      check("raw_n2_data", 64'(bus.rsp_rdata), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("raw_n3_vld",  64'(bus.rsp_valid), 64'd1);
      check("raw_n3_data", 64'(bus.rsp_rdata), 64'hCAFE_F00D);
      check("raw_n3_err",  64'(bus.rsp_err),   64'd0);
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;

      // Reset with responses queued
      send(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
      send(1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_pre_vld", 64'(bus.rsp_valid), 64'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_mid_vld",   64'(bus.rsp_valid), 64'd0);
      check("rst_mid_ready", 64'(bus.req_ready), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_post_ready", 64'(bus.req_ready), 64'd1);
      @(posedge clk);
      #1;
      xact("rst_persist", 1'b0, 32'h30, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D, 2'd0);

`ifdef DATA_RAM_PARITY_EN
      xact("par_st", 1'b1, 32'h40, 2'd2, 1'b0, 32'h4433_2211, 32'h0, 2'd0);
      dut.mem_q[16][8] = ~dut.mem_q[16][8];
      xact("par_bad41", 1'b0, 32'h41, 2'd0, 1'b0, 32'h0, 32'h0,  2'd3);
      xact("par_ok40",  1'b0, 32'h40, 2'd0, 1'b0, 32'h0, 32'h11, 2'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
